keypad_rx_port: RTL and testbench

MCU-side receiver for the keypad scanner's press/key-code output. Synchronises the slow-domain `key_press` strobe and 4-bit key code into the MCU clock domain and queues codes in a small FIFO. It raises a fixed-width interrupt pulse per queued code and exposes data and status on the MCU's `port_id`/`in_port` bus. The MCU pops or flushes the queue by writing to an acknowledge port.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_rx_port_if.sv | 13 +
 rtl/key_fifo.sv | 71 +++++++
 rtl/keypad_rx_port.sv | 146 ++++++++++++++
 tb/tb_keypad_rx_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad receive port: default port IDs,
// ack/status bit positions, interrupt FSM states and the status byte packer.
package keypad_pkg;

  localparam logic [7:0] DEF_DATA_PORT   = 8'h30;
  localparam logic [7:0] DEF_STATUS_PORT = 8'h31;
  localparam logic [7:0] DEF_ACK_PORT    = 8'h32;

  localparam int ACK_POP     = 0;
  localparam int ACK_FLUSH   = 6;
  localparam int ACK_CLR_OVF = 7;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK} int_state_t;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic [3:0] cnt);
    logic [7:0] s;
    s           = {4'h0, cnt};
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/keypad_rx_port_if.sv
// MCU-side port bus: address, write strobe/data, read data and interrupt.
interface keypad_rx_port_if;
  logic [7:0] port_id;
  logic       io_strb;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;

  modport master (output port_id, output io_strb, output out_port,
                  input in_port, input interrupt);
  modport slave  (input port_id, input io_strb, input out_port,
                  output in_port, output interrupt);
endinterface

// File: rtl/key_fifo.sv
// Small synchronous FIFO for 4-bit key codes with push/pop/flush and occupancy.
module key_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [3:0]    wdata,
  output logic [3:0]    rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/keypad_rx_port.sv
// Keypad press receiver: synchronises press/code, queues codes, pulses an
// interrupt per queued code and serves data/status/ack on the MCU port bus.
module keypad_rx_port
  import keypad_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         INT_CYCLES  = 3,
  parameter logic [7:0] DATA_PORT   = DEF_DATA_PORT,
  parameter logic [7:0] STATUS_PORT = DEF_STATUS_PORT,
  parameter logic [7:0] ACK_PORT    = DEF_ACK_PORT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_press,
  input  logic [3:0]       key_code,
  keypad_rx_port_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;

  logic       press_s1_q, press_s1_d;
  logic       press_s2_q, press_s2_d;
  logic       press_prev_q, press_prev_d;
  logic [3:0] code_s1_q, code_s1_d;
  logic [3:0] code_s2_q, code_s2_d;
  logic       overflow_q, overflow_d;

  int_state_t       state_q;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic             interrupt_q;

  logic          push, ack, pop, flush, clr_ovf;
  logic [3:0]    head;
  logic [CW-1:0] count;
  logic          full, empty, drop;
  logic [7:0]    in_port_w;
  logic          unused_ack_bits;

  assign unused_ack_bits = ^bus.out_port[5:1];

  always_comb begin
    press_s1_d   = key_press;
    press_s2_d   = press_s1_q;
    press_prev_d = press_s2_q;
    code_s1_d    = key_code;
    code_s2_d    = code_s1_q;
  end

  // The previous-press flop resets low, so a press held through reset release
  // still produces exactly one rising edge.
  assign push = press_s2_q & ~press_prev_q;

  assign ack     = bus.io_strb && (bus.port_id == ACK_PORT);
  assign flush   = ack && bus.out_port[ACK_FLUSH];
  assign pop     = ack && bus.out_port[ACK_POP] && !flush;
  assign clr_ovf = ack && bus.out_port[ACK_CLR_OVF];

  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_s1_q   <= 1'b0;
      press_s2_q   <= 1'b0;
      press_prev_q <= 1'b0;
      code_s1_q    <= 4'h0;
      code_s2_q    <= 4'h0;
      overflow_q   <= 1'b0;
    end else begin
      press_s1_q   <= press_s1_d;
      press_s2_q   <= press_s2_d;
      press_prev_q <= press_prev_d;
      code_s1_q    <= code_s1_d;
      code_s2_q    <= code_s2_d;
      overflow_q   <= overflow_d;
    end
  end

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (code_s2_q),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  // Counter holds the remaining PULSE cycles after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      interrupt_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q     <= PULSE;
            pulse_cnt_q <= CNT_W'(INT_CYCLES - 1);
            interrupt_q <= 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt_q == '0) begin
            state_q     <= WAIT_ACK;
            interrupt_q <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (pop) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          interrupt_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_port_w = 8'h00;
    if (bus.port_id == DATA_PORT) begin
      in_port_w = empty ? 8'h00 : {4'h0, head};
    end else if (bus.port_id == STATUS_PORT) begin
      in_port_w = status_byte(overflow_q, full, empty, 4'(count));
    end
  end

  assign bus.in_port   = in_port_w;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_keypad_rx_port.sv
// Directed bench for keypad_rx_port with hand-computed expected values.
module tb_keypad_rx_port;

  localparam logic [7:0] DATA_P   = 8'h30;
  localparam logic [7:0] STATUS_P = 8'h31;
  localparam logic [7:0] ACK_P    = 8'h32;

  logic       clk;
  logic       rst_n;
  logic       key_press;
  logic [3:0] key_code;

  int errors = 0;
  int checks = 0;

  keypad_rx_port_if bus ();

  keypad_rx_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_press (key_press),
    .key_code  (key_code),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] v);
    bus.port_id = id;
    #1;
    v = bus.in_port;
  endtask

  task automatic ack(input logic [7:0] d);
    bus.port_id  = ACK_P;
    bus.out_port = d;
    bus.io_strb  = 1'b1;
    step(1);
    bus.io_strb  = 1'b0;
    bus.out_port = 8'h00;
  endtask

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_press = 1'b1;
    step(3);
    key_press = 1'b0;
    step(3);
  endtask

  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step(1);
      if (bus.interrupt === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic cleanup();
    ack(8'h40);
    step(2);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    key_press = 1'b0; key_code = 4'h0;
    bus.port_id = 8'h00; bus.io_strb = 1'b0; bus.out_port = 8'h00;
    step(3);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL reset_status got=%h exp=20", v); end
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", bus.interrupt); end
    rst_n = 1'b1;
    step(2);
    rd(DATA_P, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL empty_data got=%h exp=00", v); end
    rd(8'h55, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL bad_port got=%h exp=00", v); end
  endtask

  task automatic test_one_press();
    logic [7:0] v;
    logic [9:0] iv;
    key_code = 4'h7; key_press = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      iv[i] = bus.interrupt;
      if (i == 2) begin
        rd(STATUS_P, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL count_after_k2 got=%h exp=01", v); end
      end
    end
    key_press = 1'b0;
    checks++; if (iv !== 10'b0000111000) begin errors++; $display("FAIL one_press_pulse got=%b exp=0000111000", iv); end
    rd(DATA_P, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL one_press_data got=%h exp=07", v); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL one_press_status got=%h exp=01", v); end
    step(3);
    ack(8'h01);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL one_press_popped got=%h exp=20", v); end
  endtask

  task automatic test_pop_refill();
    logic [7:0] v;
    logic [5:0] iv;
    press(4'h1);
    press(4'h2);
    step(2);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL refill_two got=%h exp=02", v); end
    ack(8'h01);
    iv[0] = bus.interrupt;
    rd(DATA_P, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL refill_data got=%h exp=02", v); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL refill_count got=%h exp=01", v); end
    for (int i = 1; i < 6; i++) begin
      step(1);
      iv[i] = bus.interrupt;
    end
    checks++; if (iv !== 6'b001110) begin errors++; $display("FAIL refill_pulse got=%b exp=001110", iv); end
    ack(8'h01);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL refill_empty got=%h exp=20", v); end
    iv = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      iv[i] = bus.interrupt;
    end
    checks++; if (iv !== 6'b000000) begin errors++; $display("FAIL refill_no_pulse got=%b exp=000000", iv); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    for (int c = 1; c <= 5; c++) press(4'(c));
    step(6);
    rd(STATUS_P, v);
    checks++; if (v !== 8'hC4) begin errors++; $display("FAIL ovf_status got=%h exp=C4", v); end
    rd(DATA_P, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL ovf_data got=%h exp=01", v); end
    ack(8'h80);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h44) begin errors++; $display("FAIL ovf_clear got=%h exp=44", v); end
    cleanup();
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL ovf_flush got=%h exp=20", v); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] v;
    logic [3:0] exp_codes [4];
    exp_codes[0] = 4'h2; exp_codes[1] = 4'h3; exp_codes[2] = 4'h4; exp_codes[3] = 4'hA;
    for (int c = 1; c <= 4; c++) press(4'(c));
    step(6);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h44) begin errors++; $display("FAIL full_before got=%h exp=44", v); end
    key_code = 4'hA; key_press = 1'b1;
    step(2);
    ack(8'h01);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h44) begin errors++; $display("FAIL full_push_pop got=%h exp=44", v); end
    key_press = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      rd(DATA_P, v);
      checks++;
      if (v !== {4'h0, exp_codes[i]}) begin
        errors++; $display("FAIL full_pop%0d got=%h exp=%h", i, v, {4'h0, exp_codes[i]});
      end
      ack(8'h01);
    end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL full_drained got=%h exp=20", v); end
    cleanup();
  endtask

  task automatic test_flush();
    logic [7:0] v;
    logic [7:0] iv;
    bit ok;
    key_code = 4'h5; key_press = 1'b1;
    wait_int(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_pulse_seen got=%b exp=1", ok); end
    ack(8'h40);
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL flush_int_low got=%b exp=0", bus.interrupt); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL flush_status got=%h exp=20", v); end
    key_press = 1'b0;
    step(3);
    key_code = 4'h9; key_press = 1'b1;
    step(2);
    ack(8'h40);
    key_press = 1'b0;
    iv = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      iv[i] = bus.interrupt;
    end
    checks++; if (iv !== 8'h00) begin errors++; $display("FAIL flush_push_no_pulse got=%b exp=00000000", iv); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL flush_push_status got=%h exp=20", v); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [7:0] v;
    logic [9:0] iv;
    bit ok;
    key_code = 4'h3; key_press = 1'b1;
    wait_int(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_pulse_seen got=%b exp=1", ok); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL rst_int_drop got=%b exp=0", bus.interrupt); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_lost got=%h exp=20", v); end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      iv[i] = bus.interrupt;
    end
    checks++; if (iv !== 10'b0000111000) begin errors++; $display("FAIL held_press_pulse got=%b exp=0000111000", iv); end
    rd(STATUS_P, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL held_press_count got=%h exp=01", v); end
    rd(DATA_P, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL held_press_data got=%h exp=03", v); end
    key_press = 1'b0;
    step(3);
    rd(STATUS_P, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL held_press_once got=%h exp=01", v); end
    cleanup();
  endtask

  initial begin
    test_reset();
    test_one_press();
    test_pop_refill();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
